mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised load/store engine between the core's MEM stage and a word-wide data memory port.
- Decodes the core's 3-bit memory-op encoding: MEM_NO=0, MEM_D=1, MEM_W=2, MEM_H=3, MEM_B=4, MEM_UB=5, MEM_UH=6, MEM_UW=7.
- Store path: generates byte masks and lane-shifted write data.
- Load path: lane-extracts read data, then sign- or zero-extends it.
- Misaligned accesses that cross a memory-word boundary are split into two beats, or rejected, depending on mode.
- Valid/ready handshake on the request side; pulsed response.

Parameters:
- XLEN, 64: data/address width; legal values 32 or 64. B = XLEN/8 bytes per memory word.
- SPLIT_EN, 1: 1 = split boundary-crossing accesses into two beats; 0 = flag them as a misalignment error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  mem_op_enum code
- req_we  in  1  1 = store, 0 = load
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  illegal op or rejected misalignment; valid with resp_valid
- mem_valid  out  1  memory beat request
- mem_ready  in  1  memory accepts beat
- mem_addr  out  XLEN  word-aligned beat address
- mem_we  out  1  beat is a write
- mem_wmask  out  B  byte write enables
- mem_wdata  out  XLEN  lane-shifted write data
- mem_rvalid  in  1  beat completion; read data for loads, write ack for stores
- mem_rdata  in  XLEN  beat read data

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_valid=0, mem_we=0; mem_addr, mem_wmask, mem_wdata = 0.
- States:
  - IDLE: req_ready=1.
  - On req_valid&&req_ready, latch op, we, addr, wdata.
  - Compute size S: D=8, W/UW=4, H/UH=2, B/UB=1.
  - Compute offset o = addr mod B; cross = (o+S > B).
  - Error cases go to ERR: op==MEM_NO; op==MEM_D with XLEN=32; cross with SPLIT_EN=0.
  - Otherwise go to REQ1.
- REQ1: mem_valid=1.
  - mem_addr = addr with low log2(B) bits cleared.
  - mem_wmask = ((1<<S)-1)<<o, truncated to B bits.
  - mem_wdata = wdata<<(8*o), truncated.
  - mem_we = latched we.
  - All mem_* outputs are held stable until mem_ready. On mem_ready, go to WAIT1.
- WAIT1: mem_valid=0. On mem_rvalid, capture mem_rdata as lo. Then go to REQ2 if cross, else DONE.
- REQ2: beat at mem_addr = aligned+B.
  - mem_wmask = ((1<<S)-1)>>(B-o).
  - mem_wdata = wdata>>(8*(B-o)).
  - Same hold rule as REQ1. On mem_ready, go to WAIT2.
- WAIT2: on mem_rvalid, capture hi. Go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
  - Load: resp_rdata = low S bytes of ({hi,lo} >> 8*o), where hi=0 for a single beat.
  - Extension: sign-extended for W/H/B; zero-extended for UW/UH/UB; D passes through.
  - Store: resp_rdata=0.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then IDLE. No memory beat is issued.
- Latency, aligned access with mem_ready=1 and mem_rvalid one cycle later:
  - accept t0; mem_valid t1; mem_rvalid t2; resp_valid t3; req_ready again t4.
  - A split access adds 2 cycles.
  - Error response at t1.
- No response backpressure. req_ready=0 in every state except IDLE.
- mem_rvalid seen outside WAIT1/WAIT2 is ignored. mem_rvalid in the same cycle as mem_ready is not legal memory behaviour; the memory returns it no earlier than the following cycle.
- Reset mid-operation: next edge returns to IDLE with all outputs at their reset values. Late mem_rvalid after reset is ignored. No resp_valid is produced for the aborted request.
- Aligned or misaligned accesses that do not cross a word boundary always use a single beat, regardless of SPLIT_EN.

Test Plan:
- LW at 0x1000, mem_rdata=0x00000000_80000000 -> mem_addr 0x1000, resp_rdata 0xFFFFFFFF_80000000. Same with LWU -> 0x00000000_80000000.
- SH at 0x1003, wdata 0xABCD -> one beat: mem_addr 0x1000, wmask 0x18, wdata 0x000000AB_CD000000; resp_valid with rdata 0.
- SD at 0x1006, wdata 0x08070605_04030201, SPLIT_EN=1 -> beat1: 0x1000, mask 0xC0, wdata 0x02010000_00000000. Beat2: 0x1008, mask 0x3F, wdata 0x00000807_06050403.
- LW at 0x100E; beat1 rdata 0xBBAA0000_00000000, beat2 rdata 0x00000000_000080FF -> resp_rdata 0xFFFFFFFF_80FFBBAA, resp_err=0.
- SPLIT_EN=0, LD at 0x1001 -> no mem_valid, resp_valid+resp_err at t1. Separately, op MEM_NO -> same error response.
- Request accepted, mem_ready held 0 for 3 cycles (mem_* stable), rst pulsed -> IDLE next edge, mem_valid=0, no resp_valid. A following LB at 0x1007 with rdata 0x80000000_00000000 returns 0xFFFFFFFF_FFFFFF80.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store engine between the MEM stage and a word-wide data memory port
// Boundary-crossing accesses are split into two beats (SPLIT_EN=1) or rejected (SPLIT_EN=0).
module mem_access_unit #(
  parameter int XLEN     = 64,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);
  localparam int B2 = 2 * B;

  localparam logic [2:0] MEM_NO = 3'd0, MEM_D = 3'd1, MEM_W = 3'd2, MEM_H = 3'd3,
                         MEM_B = 3'd4, MEM_UB = 3'd5, MEM_UH = 3'd6, MEM_UW = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_DONE, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   hi_q, hi_d;

  function automatic logic [3:0] op_size(input logic [2:0] op);
    case (op)
      MEM_D:          return 4'd8;
      MEM_W, MEM_UW:  return 4'd4;
      MEM_H, MEM_UH:  return 4'd2;
      MEM_B, MEM_UB:  return 4'd1;
      default:        return 4'd0;
    endcase
  endfunction

  function automatic logic crosses(input logic [2:0] op, input logic [OW-1:0] off);
    logic [4:0] sum;
    sum = 5'(off) + 5'(op_size(op));
    return sum > 5'(B);
  endfunction

  logic [OW-1:0]      off_q;
  logic [3:0]         size_q;
  logic               cross_q;
  logic [OW+2:0]      shamt;
  logic [B2-1:0]      mask_wide;
  logic [2*XLEN-1:0]  wdata_wide;
  logic [XLEN-1:0]    rd_sh, ld_ext, aligned;
  logic               req_err;

  assign off_q      = addr_q[OW-1:0];
  assign size_q     = op_size(op_q);
  assign cross_q    = crosses(op_q, off_q);
  assign shamt      = {off_q, 3'b000};
  // Both beats come from one double-width shift: low half is beat 1, high half is beat 2.
  assign mask_wide  = ((B2'(1) << size_q) - B2'(1)) << off_q;
  assign wdata_wide = {{XLEN{1'b0}}, wdata_q} << shamt;
  assign rd_sh      = XLEN'({hi_q, lo_q} >> shamt);
  assign aligned    = {addr_q[XLEN-1:OW], {OW{1'b0}}};

  assign req_err = (req_op == MEM_NO) ||
                   ((req_op == MEM_D) && (XLEN == 32)) ||
                   (!SPLIT_EN && crosses(req_op, req_addr[OW-1:0]));

  always_comb begin
    case (op_q)
      MEM_B:   ld_ext = XLEN'(signed'(rd_sh[7:0]));
      MEM_UB:  ld_ext = XLEN'(rd_sh[7:0]);
      MEM_H:   ld_ext = XLEN'(signed'(rd_sh[15:0]));
      MEM_UH:  ld_ext = XLEN'(rd_sh[15:0]);
      MEM_W:   ld_ext = XLEN'(signed'(rd_sh[31:0]));
      MEM_UW:  ld_ext = XLEN'(rd_sh[31:0]);
      default: ld_ext = rd_sh;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wmask  = '0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lo_d    = '0;
          hi_d    = '0;
          state_d = req_err ? S_ERR : S_REQ1;
        end
      end
      S_REQ1: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = aligned;
        mem_wmask = mask_wide[B-1:0];
        mem_wdata = wdata_wide[XLEN-1:0];
        if (mem_ready) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          lo_d    = mem_rdata;
          state_d = cross_q ? S_REQ2 : S_DONE;
        end
      end
      S_REQ2: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = aligned + XLEN'(B);
        mem_wmask = mask_wide[B2-1:B];
        mem_wdata = wdata_wide[2*XLEN-1:XLEN];
        if (mem_ready) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (mem_rvalid) begin
          hi_d    = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? '0 : ld_ext;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= MEM_NO;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit (split and reject instances)
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, mem_valid, mem_we;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        n_req_valid = 1'b0, n_req_ready, n_req_we = 1'b0;
  logic [2:0]  n_req_op = 3'd0;
  logic [63:0] n_req_addr = '0, n_req_wdata = '0;
  logic        n_resp_valid, n_resp_err, n_mem_valid, n_mem_we;
  logic [63:0] n_resp_rdata, n_mem_addr, n_mem_wdata;
  logic [7:0]  n_mem_wmask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.XLEN(64), .SPLIT_EN(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_op(n_req_op), .req_we(n_req_we),
    .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
    .mem_valid(n_mem_valid), .mem_ready(1'b0), .mem_addr(n_mem_addr), .mem_we(n_mem_we),
    .mem_wmask(n_mem_wmask), .mem_wdata(n_mem_wdata), .mem_rvalid(1'b0), .mem_rdata(64'd0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the first post-accept cycle.
  task automatic request(input logic [2:0] op, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata);
    req_op = op; req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", 64'(req_ready), 64'd0);
  endtask

  // Expects the beat to be presented now; accepts it and returns rd one cycle later.
  task automatic beat(input string tag, input logic [63:0] addr, input logic [7:0] mask,
                      input logic [63:0] wdata, input logic we, input logic [63:0] rd);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd1);
    chk({tag, "_addr"},  mem_addr, addr);
    chk({tag, "_mask"},  64'(mem_wmask), 64'(mask));
    chk({tag, "_wdata"}, mem_wdata, wdata);
    chk({tag, "_we"},    64'(mem_we), 64'(we));
    mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    chk({tag, "_wait"}, 64'(mem_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic resp(input string tag, input logic [63:0] rdata, input logic err);
    chk({tag, "_rv"},   64'(resp_valid), 64'd1);
    chk({tag, "_err"},  64'(resp_err), 64'(err));
    chk({tag, "_data"}, resp_rdata, rdata);
    @(posedge clk); @(negedge clk);
    chk({tag, "_pulse"}, 64'(resp_valid), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rv",    64'(resp_valid), 64'd0);
    chk("rst_err",   64'(resp_err), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_mv",    64'(mem_valid), 64'd0);
    chk("rst_mwe",   64'(mem_we), 64'd0);
    chk("rst_maddr", mem_addr, 64'd0);
    chk("rst_mask",  64'(mem_wmask), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);

    request(3'd2, 1'b0, 64'h1000, 64'd0);
    beat("lw", 64'h1000, 8'h0F, 64'd0, 1'b0, 64'h00000000_80000000);
    resp("lw", 64'hFFFFFFFF_80000000, 1'b0);

    request(3'd7, 1'b0, 64'h1000, 64'd0);
    beat("lwu", 64'h1000, 8'h0F, 64'd0, 1'b0, 64'h00000000_80000000);
    resp("lwu", 64'h00000000_80000000, 1'b0);

    request(3'd3, 1'b1, 64'h1003, 64'hABCD);
    beat("sh", 64'h1000, 8'h18, 64'h000000AB_CD000000, 1'b1, 64'hDEAD);
    resp("sh", 64'd0, 1'b0);

    request(3'd1, 1'b1, 64'h1006, 64'h08070605_04030201);
    beat("sd1", 64'h1000, 8'hC0, 64'h02010000_00000000, 1'b1, 64'd0);
    beat("sd2", 64'h1008, 8'h3F, 64'h00000807_06050403, 1'b1, 64'd0);
    resp("sd", 64'd0, 1'b0);

    request(3'd2, 1'b0, 64'h100E, 64'd0);
    beat("lwx1", 64'h1008, 8'hC0, 64'd0, 1'b0, 64'hBBAA0000_00000000);
    beat("lwx2", 64'h1010, 8'h03, 64'd0, 1'b0, 64'h00000000_000080FF);
    resp("lwx", 64'hFFFFFFFF_80FFBBAA, 1'b0);

    request(3'd0, 1'b0, 64'h1000, 64'd0);
    chk("memno_mv", 64'(mem_valid), 64'd0);
    resp("memno", 64'd0, 1'b1);

    n_req_op = 3'd1; n_req_we = 1'b0; n_req_addr = 64'h1001; n_req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    n_req_valid = 1'b0;
    chk("ns_ld_rv",    64'(n_resp_valid), 64'd1);
    chk("ns_ld_err",   64'(n_resp_err), 64'd1);
    chk("ns_ld_rdata", n_resp_rdata, 64'd0);
    chk("ns_ld_mv",    64'(n_mem_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("ns_ld_pulse", 64'(n_resp_valid), 64'd0);
    chk("ns_ld_mv2",   64'(n_mem_valid), 64'd0);
    chk("ns_ld_ready", 64'(n_req_ready), 64'd1);

    request(3'd2, 1'b1, 64'h1000, 64'h11223344);
    for (int i = 0; i < 3; i++) begin
      chk("hold_mv",    64'(mem_valid), 64'd1);
      chk("hold_addr",  mem_addr, 64'h1000);
      chk("hold_mask",  64'(mem_wmask), 64'h0F);
      chk("hold_wdata", mem_wdata, 64'h11223344);
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_mv",    64'(mem_valid), 64'd0);
    chk("abort_maddr", mem_addr, 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_rv",    64'(resp_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      chk("late_rv",    64'(resp_valid), 64'd0);
      chk("late_ready", 64'(req_ready), 64'd1);
      @(posedge clk); @(negedge clk);
    end

    request(3'd4, 1'b0, 64'h1007, 64'd0);
    beat("lb", 64'h1000, 8'h80, 64'd0, 1'b0, 64'h80000000_00000000);
    resp("lb", 64'hFFFFFFFF_FFFFFF80, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
